// File: rtl/keypad_entry.sv
// Debounced keypad entry: turns scanner key levels into single key events and
// builds a BCD entry with backspace and commit, driving the seven-segment display.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_DIGITS      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_down,
  input  logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [2:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] committed_value,
  output logic                    entry_valid,
  output logic                    commit_pulse,
  output logic                    overflow_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] FULL_COUNT = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] stable_count, stable_count_next;
  logic [3:0]    code, code_next;
  logic          key_event, key_event_next;

  logic [DW-1:0]         digits_next, committed_next;
  logic [NUM_DIGITS-1:0] blank_next;
  logic [2:0]            count_next;
  logic                  valid_next, commit_next, overflow_next;
  logic                  is_digit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RELEASED;
      stable_count <= '0;
      code         <= '0;
      key_event    <= 1'b0;
    end else begin
      state        <= state_next;
      stable_count <= stable_count_next;
      code         <= code_next;
      key_event    <= key_event_next;
    end
  end

  // The counter holds how many consecutive qualifying samples have been seen,
  // so the edge that observes the last one is where the counter reads LAST_SAMPLE.
  always_comb begin
    state_next        = state;
    stable_count_next = stable_count;
    code_next         = code;
    key_event_next    = 1'b0;
    case (state)
      RELEASED: begin
        if (key_down) begin
          code_next         = key_code;
          stable_count_next = CW'(1);
          state_next        = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_down) begin
          stable_count_next = '0;
          state_next        = RELEASED;
        end else if (key_code != code) begin
          code_next         = key_code;
          stable_count_next = CW'(1);
        end else if (stable_count == LAST_SAMPLE) begin
          stable_count_next = '0;
          key_event_next    = 1'b1;
          state_next        = HELD;
        end else begin
          stable_count_next = stable_count + CW'(1);
        end
      end
      HELD: begin
        if (!key_down) begin
          stable_count_next = CW'(1);
          state_next        = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_down) begin
          stable_count_next = '0;
          state_next        = HELD;
        end else if (stable_count == LAST_SAMPLE) begin
          stable_count_next = '0;
          state_next        = RELEASED;
        end else begin
          stable_count_next = stable_count + CW'(1);
        end
      end
      default: begin
        stable_count_next = '0;
        state_next        = RELEASED;
      end
    endcase
  end

  assign is_digit = (code <= 4'd9);

  // The latched code stays put while HELD, so it doubles as the event code.
  always_comb begin
    digits_next    = digits;
    count_next     = digit_count;
    committed_next = committed_value;
    valid_next     = entry_valid;
    commit_next    = 1'b0;
    overflow_next  = 1'b0;
    if (key_event) begin
      if (is_digit) begin
        if (entry_valid) begin
          digits_next = DW'(code);
          count_next  = 3'd1;
          valid_next  = 1'b0;
        end else if (digit_count != FULL_COUNT) begin
          digits_next = (digits << 4) | DW'(code);
          count_next  = digit_count + 3'd1;
        end else begin
          overflow_next = 1'b1;
        end
      end else if (code == 4'd10) begin
        if (digit_count != 3'd0) begin
          digits_next = digits >> 4;
          count_next  = digit_count - 3'd1;
          valid_next  = 1'b0;
        end
      end else if (code == 4'd11) begin
        if (digit_count != 3'd0) begin
          committed_next = digits;
          valid_next     = 1'b1;
          commit_next    = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank_next[i] = (3'(i) >= count_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digits          <= '0;
      digit_blank     <= '1;
      digit_count     <= '0;
      committed_value <= '0;
      entry_valid     <= 1'b0;
      commit_pulse    <= 1'b0;
      overflow_err    <= 1'b0;
    end else begin
      digits          <= digits_next;
      digit_blank     <= blank_next;
      digit_count     <= count_next;
      committed_value <= committed_next;
      entry_valid     <= valid_next;
      commit_pulse    <= commit_next;
      overflow_err    <= overflow_next;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios then random key traffic, checked
// every cycle against a decimal-number model of the entry and a streak-based debounce model.
module tb_keypad_entry;

  localparam int DEB = 4;
  localparam int ND  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_down = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic [4*ND-1:0] digits, committed_value;
  logic [ND-1:0] digit_blank;
  logic [2:0]    digit_count;
  logic          entry_valid, commit_pulse, overflow_err;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(DEB), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .key_code(key_code),
    .digits(digits), .digit_blank(digit_blank), .digit_count(digit_count),
    .committed_value(committed_value), .entry_valid(entry_valid),
    .commit_pulse(commit_pulse), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Model state: the entry is kept as a plain decimal number plus its length.
  int  m_val, m_cnt, m_cval;
  bit  m_valid, m_cp, m_ov;
  bit  pressed, pend;
  int  streak;
  logic [3:0] scode, pcode;

  function automatic logic [31:0] toBcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task applyKey(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (m_valid) begin
        m_val = int'(c); m_cnt = 1; m_valid = 0;
      end else if (m_cnt < ND) begin
        m_val = m_val * 10 + int'(c); m_cnt++;
      end else begin
        m_ov = 1;
      end
    end else if (c == 4'd10 && m_cnt > 0) begin
      m_val = m_val / 10; m_cnt--; m_valid = 0;
    end else if (c == 4'd11 && m_cnt > 0) begin
      m_cval = m_val; m_valid = 1; m_cp = 1;
    end
  endtask

  // A press is accepted after DEB equal-code high samples, a release after DEB low samples;
  // the entry reacts one edge after acceptance.
  always @(posedge clk) begin
    m_cp = 0;
    m_ov = 0;
    if (!rst) begin
      m_val = 0; m_cnt = 0; m_cval = 0; m_valid = 0;
      pressed = 0; pend = 0; streak = 0; scode = '0; pcode = '0;
    end else begin
      if (pend) applyKey(pcode);
      pend = 0;
      if (!pressed) begin
        if (key_down) begin
          if (streak > 0 && key_code == scode) streak++;
          else begin streak = 1; scode = key_code; end
          if (streak == DEB) begin pressed = 1; streak = 0; pend = 1; pcode = scode; end
        end else streak = 0;
      end else begin
        if (!key_down) begin
          streak++;
          if (streak == DEB) begin pressed = 0; streak = 0; end
        end else streak = 0;
      end
    end
  end

  task cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task checkOutput();
    logic [31:0] blank_exp;
    blank_exp = '0;
    for (int i = 0; i < ND; i++) blank_exp[i] = (i >= m_cnt);
    cmp("digits", 32'(digits), toBcd(m_val));
    cmp("digit_count", 32'(digit_count), 32'(m_cnt));
    cmp("digit_blank", 32'(digit_blank), blank_exp);
    cmp("committed_value", 32'(committed_value), toBcd(m_cval));
    cmp("entry_valid", 32'(entry_valid), 32'(m_valid));
    cmp("commit_pulse", 32'(commit_pulse), 32'(m_cp));
    cmp("overflow_err", 32'(overflow_err), 32'(m_ov));
  endtask

  task applyStimulus(input logic kd, input logic [3:0] c, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
      key_down = kd;
      key_code = c;
      rst = r;
    end
  endtask

  task pressKey(input logic [3:0] c);
    applyStimulus(1'b1, c, 1'b1, 10);
    applyStimulus(1'b0, 4'd0, 1'b1, 10);
  endtask

  task resetDut();
    applyStimulus(1'b0, 4'd0, 1'b0, 2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1);
  endtask

  initial begin
    resetDut();

    // Short press never reaches the debounce threshold.
    applyStimulus(1'b1, 4'd1, 1'b1, 3);
    applyStimulus(1'b0, 4'd0, 1'b1, 10);
    @(negedge clk);
    cmp("short_count", 32'(digit_count), 32'd0);
    cmp("short_blank", 32'(digit_blank), 32'h3f);

    pressKey(4'd1); pressKey(4'd2); pressKey(4'd3);
    @(negedge clk);
    cmp("seq_digits", 32'(digits), 32'h000123);
    cmp("seq_count", 32'(digit_count), 32'd3);
    cmp("seq_blank", 32'(digit_blank), 32'h38);

    // Long hold with a brief dropout adds exactly one digit.
    applyStimulus(1'b1, 4'd5, 1'b1, 500);
    applyStimulus(1'b0, 4'd5, 1'b1, 2);
    applyStimulus(1'b1, 4'd5, 1'b1, 498);
    applyStimulus(1'b0, 4'd0, 1'b1, 10);
    @(negedge clk);
    cmp("hold_digits", 32'(digits), 32'h001235);

    resetDut();
    for (int d = 1; d <= 7; d++) pressKey(4'(d));
    @(negedge clk);
    cmp("full_digits", 32'(digits), 32'h123456);
    pressKey(4'd10);
    @(negedge clk);
    cmp("bksp_digits", 32'(digits), 32'h012345);
    cmp("bksp_count", 32'(digit_count), 32'd5);

    resetDut();
    pressKey(4'd4); pressKey(4'd2); pressKey(4'd11);
    @(negedge clk);
    cmp("commit_value", 32'(committed_value), 32'h000042);
    cmp("commit_valid", 32'(entry_valid), 32'd1);
    pressKey(4'd11);
    pressKey(4'd9);
    @(negedge clk);
    cmp("new_digits", 32'(digits), 32'h000009);
    cmp("new_valid", 32'(entry_valid), 32'd0);
    cmp("held_commit", 32'(committed_value), 32'h000042);

    // Empty-entry no-ops, then reset in the middle of a press.
    resetDut();
    pressKey(4'd11); pressKey(4'd10); pressKey(4'd13);
    applyStimulus(1'b1, 4'd7, 1'b1, 2);
    applyStimulus(1'b1, 4'd7, 1'b0, 1);
    applyStimulus(1'b1, 4'd7, 1'b1, 8);
    applyStimulus(1'b0, 4'd0, 1'b1, 10);
    @(negedge clk);
    cmp("rst_press_digits", 32'(digits), 32'h000007);

    for (int s = 0; s < 400; s++) begin
      logic [3:0] c;
      logic kd;
      c = 4'($urandom_range(0, 15));
      if (c >= 4'd12 && $urandom_range(0, 3) != 0) c = c - 4'd10;
      kd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) applyStimulus(kd, c, 1'b0, 1);
      applyStimulus(kd, c, 1'b1, $urandom_range(1, 8));
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Downstream consumer of the keypad scanner's decoded key stream.
- Debounces the key level, turns each accepted press into exactly one key event, and builds a 6-digit BCD entry.
- Supports backspace (code 10, '*') and commit (code 11, '#').
- Drives the packed digit value and per-digit blanking mask consumed by the 6-digit seven-segment display multiplexer.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk samples required to accept a press or a release (10 ms at 50 MHz); legal range 2..2^24-1; internal counter width is clog2(DEBOUNCE_CYCLES+1).
- NUM_DIGITS, 6, entry depth in BCD digits; digit_count width fixed at 3 bits, so legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- key_down  in  1  level from scanner: a key is currently detected
- key_code  in  4  scanner code, valid while key_down=1 (0-9 digits, 10 '*', 11 '#', 12-15 unused)
- digits  out  4*NUM_DIGITS  working entry, digit 0 (rightmost, newest) in bits [3:0]
- digit_blank  out  NUM_DIGITS  bit i=1 when display digit i must be blank
- digit_count  out  3  number of digits in the working entry, 0..NUM_DIGITS
- committed_value  out  4*NUM_DIGITS  value latched at the last commit
- entry_valid  out  1  committed_value is current; no new entry has been started since the commit
- commit_pulse  out  1  one-cycle strobe when a commit is accepted
- overflow_err  out  1  one-cycle strobe when a digit is pressed while the entry is full

Behaviour:
- Reset (rst=0 at a clk edge): all outputs return to 0, except digit_blank which returns to all ones; debounce FSM goes to RELEASED, counter 0, latched code 0. Reset overrides any in-progress debounce or event.
- Debounce FSM: states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
- RELEASED, key_down=1: latch key_code, counter=1, go to PRESS_WAIT.
- PRESS_WAIT, key_down=0: go to RELEASED, no event.
- PRESS_WAIT, key_code differs from latched code: re-latch the code, counter=1.
- PRESS_WAIT, same code and counter reaches DEBOUNCE_CYCLES: go to HELD and assert the internal key_event for exactly one cycle with the latched code.
- HELD, key_down=0: counter=1, go to RELEASE_WAIT. HELD never generates repeats, however long the key is held.
- RELEASE_WAIT, key_down=1: back to HELD, no event.
- RELEASE_WAIT, key_down=0 for DEBOUNCE_CYCLES consecutive samples: go to RELEASED.
- Latency: key_down must be sampled high with a stable code on DEBOUNCE_CYCLES consecutive edges. The entry outputs (digits, digit_count, digit_blank, committed_value, entry_valid, commit_pulse, overflow_err) update on the following edge, which is fixed 1-cycle latency after key_event.
- Entry processing on key_event:
  - Digit, entry_valid=1: start a new entry. digits={0,code}, digit_count=1, entry_valid=0.
  - Digit, digit_count<NUM_DIGITS: digits=(digits<<4)|code, digit_count+1.
  - Digit, digit_count==NUM_DIGITS: no change, overflow_err=1 for one cycle.
  - Code 10, digit_count>0: digits>>=4 (zero-fill at the top), digit_count-1, entry_valid=0.
  - Code 10, digit_count==0: no-op.
  - Code 11, digit_count>0: committed_value=digits, entry_valid=1, commit_pulse=1 for one cycle. digits and digit_count are kept, so the display keeps showing the number.
  - Code 11, digit_count==0: ignored, no pulse.
  - Codes 12-15: ignored, no strobe.
- Repeated '#' with entry_valid=1: re-commits the same value and pulses again.
- digit_blank[i] = (i >= digit_count), registered together with digit_count.
- Unused high nibbles of digits are always 0.
- commit_pulse and overflow_err are never both high; each is high for at most one cycle per key_event.

Test Plan:
- DEBOUNCE_CYCLES=4, press code 1 for 3 cycles then release -> no change; digit_count=0, digit_blank=6'b111111.
- Press 1,2,3, each held 10 cycles and released 10 cycles -> digits=24'h000123, digit_count=3, digit_blank=6'b111000. Each update occurs exactly 1 cycle after the 4th high sample.
- Hold code 5 for 1000 cycles, with key_down bouncing 0 for 2 cycles in the middle -> exactly one 5 is added.
- Enter 1-2-3-4-5-6, then 7 -> digits=24'h123456 unchanged, overflow_err high 1 cycle. Then '*' -> 24'h012345, digit_count=5.
- Enter 4,2 then '#' -> commit_pulse 1 cycle, committed_value=24'h000042, entry_valid=1. Then digit 9 -> digits=24'h000009, digit_count=1, entry_valid=0, committed_value held at 24'h000042.
- '#' and '*' on an empty entry -> no strobes, outputs unchanged. rst=0 during PRESS_WAIT, then key still held after rst=1 -> outputs reset, and the press is re-debounced from count 1.
